// File: rtl/usb_ep_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the EP2 bulk-IN FIFO write port among NUM_SRC byte sources.
// A fired byte reaches o_tx_dval/o_tx_data one cycle later; i_fifo_afull drops ready and freezes the idle timeout.
module usb_ep_tx_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int IDLE_TIMEOUT = 256,
  parameter int CNT_W        = 12
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   i_usb_busreset,
  input  logic                   i_highspeed,
  input  logic [NUM_SRC-1:0]     i_src_en,
  input  logic [NUM_SRC-1:0]     i_src_valid,
  input  logic [NUM_SRC-1:0]     i_src_last,
  input  logic [8*NUM_SRC-1:0]   i_src_data,
  output logic [NUM_SRC-1:0]     o_src_ready,
  input  logic                   i_fifo_afull,
  output logic                   o_tx_dval,
  output logic [7:0]             o_tx_data,
  output logic [NUM_SRC-1:0]     o_grant,
  output logic                   o_pkt_done,
  output logic [CNT_W-1:0]       o_pkt_len
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int IDL_W = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W:0]     idx;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]   maxp_q, maxp_d;
  logic [CNT_W-1:0]   pkt_len_d;
  logic [IDL_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [NUM_SRC-1:0] cand;
  logic               found;
  logic               fire;
  logic               end_pkt;
  logic               pkt_done_d;
  logic               g_last;
  logic               g_en;
  logic [7:0]         g_data;

  always_comb begin
    o_src_ready = '0;
    if (state_q == S_XFER && !i_fifo_afull) o_src_ready = o_grant;
  end

  assign fire = |(o_src_ready & i_src_valid);
  assign cand = i_src_en & i_src_valid;

  always_comb begin
    g_data = '0;
    g_last = 1'b0;
    g_en   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (gidx_q == IDX_W'(k)) begin
        g_data = i_src_data[8*k +: 8];
        g_last = i_src_last[k];
        g_en   = i_src_en[k];
      end
    end
  end

  // First enabled+valid source at or above the rr pointer, wrapping at NUM_SRC.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (idx >= (IDX_W+1)'(NUM_SRC)) idx = idx - (IDX_W+1)'(NUM_SRC);
      if (!found && cand[idx[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = o_grant;
    gidx_d     = gidx_q;
    rr_d       = rr_q;
    byte_cnt_d = byte_cnt_q;
    idle_cnt_d = idle_cnt_q;
    maxp_d     = maxp_q;
    pkt_done_d = 1'b0;
    pkt_len_d  = o_pkt_len;
    end_pkt    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d    = S_XFER;
          grant_d    = NUM_SRC'(1) << pick;
          gidx_d     = pick;
          byte_cnt_d = '0;
          idle_cnt_d = '0;
          maxp_d     = i_highspeed ? CNT_W'(512) : CNT_W'(64);
        end
      end
      S_XFER: begin
        if (fire) begin
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          idle_cnt_d = '0;
        end else if (!i_fifo_afull) begin
          idle_cnt_d = idle_cnt_q + IDL_W'(1);
        end
        // Timeout only advances while the FIFO can accept, so backpressure never ends a packet.
        end_pkt = (fire && (g_last || byte_cnt_q == maxp_q - CNT_W'(1)))
               || (!fire && !i_fifo_afull && idle_cnt_q == IDL_W'(IDLE_TIMEOUT - 1))
               || !g_en;
        if (end_pkt) begin
          state_d    = S_DONE;
          grant_d    = '0;
          pkt_done_d = 1'b1;
          pkt_len_d  = byte_cnt_d;
          rr_d       = (gidx_q == IDX_W'(NUM_SRC - 1)) ? '0 : gidx_q + IDX_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (i_usb_busreset) begin
      state_d    = S_IDLE;
      grant_d    = '0;
      rr_d       = '0;
      byte_cnt_d = '0;
      idle_cnt_d = '0;
      pkt_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      o_grant    <= '0;
      gidx_q     <= '0;
      rr_q       <= '0;
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
      maxp_q     <= '0;
      o_pkt_done <= 1'b0;
      o_pkt_len  <= '0;
      o_tx_dval  <= 1'b0;
      o_tx_data  <= '0;
    end else begin
      state_q    <= state_d;
      o_grant    <= grant_d;
      gidx_q     <= gidx_d;
      rr_q       <= rr_d;
      byte_cnt_q <= byte_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      maxp_q     <= maxp_d;
      o_pkt_done <= pkt_done_d;
      o_pkt_len  <= pkt_len_d;
      o_tx_dval  <= fire & ~i_usb_busreset;
      if (fire) o_tx_data <= g_data;
    end
  end

endmodule

// File: tb/tb_usb_ep_tx_arbiter.sv
// Directed bench for usb_ep_tx_arbiter: source model, FIFO-side scoreboard and per-step assertions.
module tb_usb_ep_tx_arbiter;

  localparam int NS = 4;

  logic            clk_i, rstn_i, i_usb_busreset, i_highspeed, i_fifo_afull;
  logic [NS-1:0]   i_src_en, i_src_valid, i_src_last, o_src_ready, o_grant;
  logic [8*NS-1:0] i_src_data;
  logic            o_tx_dval, o_pkt_done;
  logic [7:0]      o_tx_data;
  logic [11:0]     o_pkt_len;

  usb_ep_tx_arbiter #(.NUM_SRC(NS), .IDLE_TIMEOUT(256), .CNT_W(12)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .i_usb_busreset(i_usb_busreset),
    .i_highspeed(i_highspeed), .i_src_en(i_src_en), .i_src_valid(i_src_valid),
    .i_src_last(i_src_last), .i_src_data(i_src_data), .o_src_ready(o_src_ready),
    .i_fifo_afull(i_fifo_afull), .o_tx_dval(o_tx_dval), .o_tx_data(o_tx_data),
    .o_grant(o_grant), .o_pkt_done(o_pkt_done), .o_pkt_len(o_pkt_len)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  // Source model state (owned by the stimulus process)
  int          rem [NS];
  int          seq [NS];
  bit          use_last [NS];
  logic [NS-1:0] fm;

  // FIFO-side observation (owned by the monitor process)
  int done_len[$];
  int done_cyc[$];
  int grant_src[$];
  int grant_gap[$];
  int sb_cnt [NS];
  int bad = 0;
  int nbytes = 0;
  int last_dval_cyc = 0;
  int prev_src = -1;
  int zero_run = 0;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  function automatic int oh_idx(input logic [NS-1:0] v);
    oh_idx = -1;
    for (int k = 0; k < NS; k++) if (v[k]) oh_idx = k;
  endfunction

  always @(negedge clk_i) begin
    int g;
    g = oh_idx(o_grant);
    if (o_tx_dval) begin
      if (prev_src < 0) bad++;
      else begin
        if (o_tx_data !== 8'(prev_src*64 + sb_cnt[prev_src])) bad++;
        sb_cnt[prev_src]++;
      end
      nbytes++;
      last_dval_cyc = cyc;
    end
    // a byte accepted in the bus-reset cycle never reaches the FIFO
    if (i_usb_busreset && (o_src_ready & i_src_valid) != '0)
      sb_cnt[oh_idx(o_src_ready & i_src_valid)]++;
    if (o_pkt_done) begin
      done_len.push_back(int'(o_pkt_len));
      done_cyc.push_back(cyc);
    end
    if ($countones(o_grant) > 1) bad++;
    if (g >= 0 && prev_src < 0) begin
      grant_src.push_back(g);
      grant_gap.push_back(zero_run);
      zero_run = 0;
    end
    if (g < 0) zero_run++;
    prev_src = g;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int k = 0; k < NS; k++) begin
      i_src_valid[k]      = (rem[k] > 0);
      i_src_last[k]       = use_last[k] && (rem[k] == 1);
      i_src_data[8*k +: 8] = 8'(k*64 + seq[k]);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    fm = o_src_ready & i_src_valid;
    @(posedge clk_i);
    #1;
    for (int k = 0; k < NS; k++) begin
      if (fm[k]) begin
        seq[k]++;
        rem[k]--;
      end
    end
    apply();
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    int i;
    i = 0;
    while (done_len.size() < n && i < budget) begin tick(); i++; end
    ok = (done_len.size() >= n);
  endtask

  task automatic wait_grants(input int n, input int budget, output bit ok);
    int i;
    i = 0;
    while (grant_src.size() < n && i < budget) begin tick(); i++; end
    ok = (grant_src.size() >= n);
  endtask

  task automatic wait_seq(input int k, input int target, input int budget, output bit ok);
    int i;
    i = 0;
    while (seq[k] < target && i < budget) begin tick(); i++; end
    ok = (seq[k] >= target);
  endtask

  initial begin
    bit ok;
    int gb, db, s0, nb, hits;

    rstn_i = 1'b0; i_usb_busreset = 1'b0; i_highspeed = 1'b0;
    i_fifo_afull = 1'b0; i_src_en = '0; fm = '0;
    for (int k = 0; k < NS; k++) begin rem[k] = 0; seq[k] = 0; use_last[k] = 1'b0; end
    apply();
    repeat (3) tick();
    check("rst_grant", o_grant, 0);
    check("rst_dval", o_tx_dval, 0);
    check("rst_pkt_done", o_pkt_done, 0);
    check("rst_pkt_len", o_pkt_len, 0);
    check("rst_ready", o_src_ready, 0);
    rstn_i = 1'b1;
    tick(); tick();

    // Single FS source, 100 bytes, no last: 64 by MAXP, 36 by idle timeout
    db = done_len.size(); nb = nbytes;
    i_highspeed = 1'b0; i_src_en = 4'b0001; rem[0] = 100; apply();
    wait_done(db + 2, 3000, ok);
    check("t1_wait", ok, 1);
    check("t1_len_a", done_len[db], 64);
    check("t1_len_b", done_len[db+1], 36);
    check("t1_timeout_cycles", done_cyc[db+1] - last_dval_cyc, 256);
    check("t1_byte_count", nbytes - nb, 100);
    check("t1_byte_order", bad, 0);

    i_usb_busreset = 1'b1; tick(); i_usb_busreset = 1'b0; tick();

    // HS round robin over all four sources
    gb = grant_src.size(); db = done_len.size();
    i_highspeed = 1'b1; i_src_en = 4'b1111;
    for (int k = 0; k < NS; k++) rem[k] = 2000;
    apply();
    wait_grants(gb + 5, 4000, ok);
    check("t2_wait_grants", ok, 1);
    i_src_en = 4'b0000;
    wait_done(db + 5, 100, ok);
    check("t2_wait_done", ok, 1);
    for (int k = 0; k < NS; k++) rem[k] = 0;
    apply();
    for (int i = 0; i < 5; i++) check("t2_grant_order", grant_src[gb+i], i % 4);
    for (int i = 0; i < 4; i++) begin
      check("t2_len", done_len[db+i], 512);
      check("t2_gap", grant_gap[gb+i+1], 2);
    end

    // Last on 10th byte of source 2 while source 1 waits
    gb = grant_src.size(); db = done_len.size();
    i_highspeed = 1'b0; i_src_en = 4'b0110; rem[1] = 1; use_last[1] = 1'b1; apply();
    wait_done(db + 1, 100, ok);
    check("t3_wait_a", ok, 1);
    use_last[1] = 1'b0; rem[1] = 50; rem[2] = 10; use_last[2] = 1'b1; apply();
    wait_grants(gb + 3, 200, ok);
    check("t3_wait_b", ok, 1);
    check("t3_grant_a", grant_src[gb], 1);
    check("t3_grant_b", grant_src[gb+1], 2);
    check("t3_grant_wrap", grant_src[gb+2], 1);
    check("t3_len_a", done_len[db], 1);
    check("t3_len_last", done_len[db+1], 10);
    i_src_en = 4'b0000;
    wait_done(db + 3, 100, ok);
    check("t3_wait_c", ok, 1);
    for (int k = 0; k < NS; k++) begin rem[k] = 0; use_last[k] = 1'b0; end
    apply();

    // FIFO almost-full for 1000 cycles mid-packet
    db = done_len.size();
    i_src_en = 4'b0001; rem[0] = 600; apply(); s0 = seq[0];
    wait_seq(0, s0 + 20, 200, ok);
    check("t4_wait_a", ok, 1);
    i_fifo_afull = 1'b1; hits = 0;
    repeat (1000) begin
      tick();
      if (o_src_ready != '0) hits++;
    end
    check("t4_ready_low", hits, 0);
    check("t4_no_timeout", done_len.size(), db);
    check("t4_grant_held", o_grant, 1);
    check("t4_no_fire", seq[0] - s0, 20);
    i_fifo_afull = 1'b0;
    wait_done(db + 1, 200, ok);
    check("t4_wait_b", ok, 1);
    rem[0] = 0; apply();
    check("t4_len", done_len[db], 64);
    check("t4_fired", seq[0] - s0, 64);

    // Bus reset after 30 bytes of source 1
    i_src_en = 4'b0111;
    for (int k = 0; k < 3; k++) rem[k] = 1000;
    apply(); s0 = seq[1];
    wait_seq(1, s0 + 30, 200, ok);
    check("t5_wait_a", ok, 1);
    i_usb_busreset = 1'b1; tick(); i_usb_busreset = 1'b0;
    check("t5_grant_clr", o_grant, 0);
    check("t5_ready_clr", o_src_ready, 0);
    check("t5_dval_drop", o_tx_dval, 0);
    db = done_len.size(); gb = grant_src.size();
    wait_done(db + 1, 200, ok);
    check("t5_wait_b", ok, 1);
    check("t5_restart_src", grant_src[gb], 0);
    check("t5_len", done_len[db], 64);

    // Enable mask 0101 with everyone valid
    i_src_en = 4'b0101; gb = grant_src.size(); apply();
    wait_grants(gb + 4, 600, ok);
    check("t6_wait", ok, 1);
    for (int i = 0; i < 4; i++) check("t6_grant", grant_src[gb+i], (i % 2 == 0) ? 2 : 0);

    // Async reset in the middle of a transfer
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin tick(); ok = o_tx_dval; end
    check("t7_wait", ok, 1);
    check("t7_prev_len", o_pkt_len, 64);
    #2 rstn_i = 1'b0;
    #1;
    check("t7_grant", o_grant, 0);
    check("t7_dval", o_tx_dval, 0);
    check("t7_data", o_tx_data, 0);
    check("t7_pkt_done", o_pkt_done, 0);
    check("t7_pkt_len", o_pkt_len, 0);
    check("t7_ready", o_src_ready, 0);
    check("sb_byte_stream", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/usb_ep_tx_arbiter.md
Name: usb_ep_tx_arbiter

Overview:
Packet-granular round-robin arbiter that shares the single bulk-IN endpoint write port of the USB endpoint FIFO among NUM_SRC byte-stream sources. It sits between user data producers and the usb_fifo EP2 TX port (i_ep2_tx_dval/i_ep2_tx_data) and runs in the PHY_CLKOUT domain. A grant is held for one USB packet: max-packet bytes (512 HS / 64 FS), a source-marked last byte, or an idle timeout, whichever comes first. Packets from different sources are therefore never interleaved within one USB max-packet.

Parameters:
NUM_SRC, 4, number of requesters (2..8)
IDLE_TIMEOUT, 256, cycles without a transfer from the granted source before the grant is released (short packet)
CNT_W, 12, packet byte counter width

Ports:
clk_i  input  1  PHY_CLKOUT domain clock
rstn_i  input  1  asynchronous active-low reset
i_usb_busreset  input  1  USB bus reset, synchronous abort
i_highspeed  input  1  1: max packet 512; 0: max packet 64
i_src_en  input  NUM_SRC  per-source enable mask
i_src_valid  input  NUM_SRC  per-source byte valid
i_src_last  input  NUM_SRC  per-source last byte of packet, qualified by valid
i_src_data  input  8*NUM_SRC  per-source byte; source k uses [8k+7:8k]
o_src_ready  output  NUM_SRC  per-source ready, combinational
i_fifo_afull  input  1  FIFO almost full; stalls transfers
o_tx_dval  output  1  registered write strobe to the FIFO TX port
o_tx_data  output  8  registered write byte
o_grant  output  NUM_SRC  one-hot current grant, 0 when none
o_pkt_done  output  1  one-cycle pulse when a grant ends
o_pkt_len  output  CNT_W  bytes in the finished packet, valid with o_pkt_done

Behaviour:
- Reset (rstn_i low, async): state=IDLE; o_tx_dval=0, o_tx_data=0, o_grant=0, o_pkt_done=0, o_pkt_len=0; rr pointer=0; counters=0.
- MAXP = i_highspeed ? 512 : 64, sampled at grant time and held for the packet.
- fire = o_src_ready[g] & i_src_valid[g]. o_src_ready[k] = (state==XFER) & o_grant[k] & ~i_fifo_afull. Non-granted ready is always 0.
- o_tx_dval <= fire; o_tx_data <= i_src_data[g]. Each fired byte appears at the FIFO exactly 1 cycle later. No byte is dropped or duplicated.
- IDLE: go to XFER when any k has i_src_en[k] & i_src_valid[k]. Grant goes to the first such k searching upward from rr (wrapping at NUM_SRC). Set o_grant one-hot, byte_cnt=0, idle_cnt=0. Grant is registered; the earliest fire is the cycle after leaving IDLE.
- XFER: on fire, byte_cnt+1 and idle_cnt=0. With no fire and ~i_fifo_afull, idle_cnt+1. While i_fifo_afull, idle_cnt holds, so backpressure never causes a timeout.
- XFER ends, going to DONE, on whichever occurs first:
  - fire with i_src_last[g];
  - fire with byte_cnt==MAXP-1;
  - idle_cnt==IDLE_TIMEOUT-1 with no fire;
  - i_src_en[g] deasserted.
  The ending byte still counts.
- DONE (1 cycle): o_pkt_done=1, o_pkt_len=final byte_cnt (0 allowed on timeout/disable with no bytes), o_grant=0, rr=g+1 mod NUM_SRC; then IDLE. Minimum gap between grants is 2 cycles (DONE + IDLE).
- i_usb_busreset (sync, highest priority): state=IDLE, o_grant=0, ready=0, o_tx_dval=0 next cycle, rr=0, no o_pkt_done. A byte fired in the same cycle is discarded.
- Simultaneous last and MAXP boundary: one packet ends, length=MAXP.
- i_highspeed change mid-packet: ignored until next grant.
- Disabled sources never win arbitration, even if valid.

Test Plan:
- Single source 0, FS, 100 bytes continuous valid, no last -> packets of 64 then 36. The 36-byte packet ends via timeout after 256 idle cycles; o_pkt_len=64, 36; FIFO byte sequence is identical to the input.
- Sources 0..3 all continuously valid, HS -> grants cycle 0,1,2,3,0. Each packet is 512 bytes, o_pkt_done pulses 4 times, there is no interleaving within a packet, and there are 2 idle cycles between packets.
- Source 2 asserts last on its 10th byte while source 1 waits -> o_pkt_len=10, next grant goes to source 3 if valid, otherwise wraps to source 1.
- i_fifo_afull held high for 1000 cycles mid-packet -> o_src_ready=0 and no timeout. After release the packet resumes and completes at MAXP.
- i_usb_busreset pulsed after 30 bytes of a packet -> o_grant=0 the next cycle, no o_pkt_done, rr=0. The next packet starts from source 0 at byte count 0.
- Async rstn_i asserted mid-XFER -> all outputs are 0 immediately. Also check that i_src_en=4'b0101 with all sources valid yields grants alternating 0,2 only.
